// File: rtl/carry4_serial_addsub_pkg.sv
// Shared definitions for the slice-serial CARRY4 adder/subtractor:
// controller states, slice width and the slice-count / index-width helpers.
package carry4_serial_addsub_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int SLICE_W = 4;

  // Number of 4-bit slices needed to cover a WIDTH-bit operand.
  function automatic int num_slices(input int width);
    return width / SLICE_W;
  endfunction

  // Bits needed for the slice index; a single-slice design still gets one bit.
  function automatic int idx_width(input int width);
    int n;
    n = num_slices(width);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/CARRY4.sv
// Behavioural model of the CARRY4 slice: four-stage mux carry chain with
// XOR sum outputs. The chain input is CI or CYINIT; a slice that chains
// from CI holds CYINIT inactive.
module CARRY4 (
  input  logic [3:0] S,
  input  logic [3:0] DI,
  input  logic       CI,
  input  logic       CYINIT,
  output logic [3:0] O,
  output logic [3:0] CO
);

  logic [4:0] w_c;

  // Ripple through the four MUXCY stages: propagate when S is high, else generate from DI.
  always_comb begin
    w_c    = '0;
    O      = '0;
    CO     = '0;
    w_c[0] = CI | CYINIT;
    for (int i = 0; i < 4; i++) begin
      O[i]     = S[i] ^ w_c[i];
      w_c[i+1] = S[i] ? w_c[i] : DI[i];
      CO[i]    = w_c[i+1];
    end
  end

endmodule

// File: rtl/carry4_serial_addsub.sv
// WIDTH-bit add/subtract that reuses one CARRY4 slice, walking the operands
// four bits per cycle from LSB to MSB and carrying CO[3] between cycles.
//
// state | meaning
// IDLE  | waiting for START; SUM/COUT/OVF hold the last completed result
// RUN   | one slice per enabled clock, index r_idx selects the nibble
module carry4_serial_addsub
  import carry4_serial_addsub_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             C,
  input  logic             CLR,
  input  logic             CE,
  input  logic             START,
  input  logic             SUB,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             BUSY,
  output logic             DONE,
  output logic [WIDTH-1:0] SUM,
  output logic             COUT,
  output logic             OVF
);

  localparam int N  = num_slices(WIDTH);
  localparam int IW = idx_width(WIDTH);
  localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

  if ((WIDTH < SLICE_W) || ((WIDTH % SLICE_W) != 0)) begin : g_bad_width
    $error("carry4_serial_addsub: WIDTH must be a positive multiple of 4");
  end

  state_t              r_state;
  state_t              w_state_nxt;
  logic [IW-1:0]       r_idx;
  logic                r_cy;
  logic [WIDTH-1:0]    r_a;
  logic [WIDTH-1:0]    r_b;
  logic [WIDTH-1:0]    r_sum;
  logic                r_cout;
  logic                r_ovf;
  logic                r_done;

  logic                w_last;
  logic [SLICE_W-1:0]  w_a_sl;
  logic [SLICE_W-1:0]  w_b_sl;
  logic [SLICE_W-1:0]  w_s;
  logic [SLICE_W-1:0]  w_o;
  logic [SLICE_W-1:0]  w_co;
  logic                w_co_unused;

  assign w_last      = (r_state == RUN) && (r_idx == LAST_IDX);
  assign w_co_unused = ^w_co[1:0];

  // Select the current nibble of each operand; constant part-selects keep every index in range.
  always_comb begin
    w_a_sl = '0;
    w_b_sl = '0;
    for (int k = 0; k < N; k++) begin
      if (r_idx == IW'(k)) begin
        w_a_sl = r_a[k*SLICE_W +: SLICE_W];
        w_b_sl = r_b[k*SLICE_W +: SLICE_W];
      end
    end
  end

  assign w_s = w_a_sl ^ w_b_sl;

  CARRY4 u_carry4 (
    .S      (w_s),
    .DI     (w_a_sl),
    .CI     (r_cy),
    .CYINIT (1'b0),
    .O      (w_o),
    .CO     (w_co)
  );

  // Controller state register; CE freezes it, CLR abandons any operation.
  always_ff @(posedge C or posedge CLR) begin
    if (CLR) begin
      r_state <= IDLE;
    end else if (CE) begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode: accept START only from IDLE, return after the last slice.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: if (START) w_state_nxt = RUN;
      RUN:  if (r_idx == LAST_IDX) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Operand latch, per-slice result write-back, carry chaining and completion flags.
  always_ff @(posedge C or posedge CLR) begin
    if (CLR) begin
      r_idx  <= '0;
      r_cy   <= 1'b0;
      r_a    <= '0;
      r_b    <= '0;
      r_sum  <= '0;
      r_cout <= 1'b0;
      r_ovf  <= 1'b0;
      r_done <= 1'b0;
    end else if (CE) begin
      r_done <= w_last;
      if (r_state == IDLE) begin
        if (START) begin
          // Subtraction is A + ~B + 1: invert B here and seed the carry with SUB.
          r_a   <= A;
          r_b   <= B ^ {WIDTH{SUB}};
          r_cy  <= SUB;
          r_idx <= '0;
        end
      end else begin
        for (int k = 0; k < N; k++) begin
          if (r_idx == IW'(k)) begin
            r_sum[k*SLICE_W +: SLICE_W] <= w_o;
          end
        end
        r_cy  <= w_co[3];
        r_idx <= w_last ? '0 : r_idx + 1'b1;
        if (w_last) begin
          r_cout <= w_co[3];
          r_ovf  <= w_co[3] ^ w_co[2];
        end
      end
    end
  end

  assign BUSY = (r_state == RUN);
  assign DONE = r_done;
  assign SUM  = r_sum;
  assign COUT = r_cout;
  assign OVF  = r_ovf;

endmodule

// File: tb/tb_carry4_serial_addsub.sv
// Directed bench for carry4_serial_addsub at WIDTH 8, 32 and 4.
module tb_carry4_serial_addsub;

  logic        C = 1'b0;
  logic        CLR;
  logic        CE;
  logic        sub_in;
  logic [31:0] a_in;
  logic [31:0] b_in;
  logic        start8, start32, start4;

  logic        busy8, done8, cout8, ovf8;
  logic [7:0]  sum8;
  logic        busy32, done32, cout32, ovf32;
  logic [31:0] sum32;
  logic        busy4, done4, cout4, ovf4;
  logic [3:0]  sum4;

  int n_checks = 0;
  int n_err    = 0;

  always #5 C = ~C;

  carry4_serial_addsub #(.WIDTH(8)) dut8 (
    .C(C), .CLR(CLR), .CE(CE), .START(start8), .SUB(sub_in),
    .A(a_in[7:0]), .B(b_in[7:0]),
    .BUSY(busy8), .DONE(done8), .SUM(sum8), .COUT(cout8), .OVF(ovf8)
  );

  carry4_serial_addsub #(.WIDTH(32)) dut32 (
    .C(C), .CLR(CLR), .CE(CE), .START(start32), .SUB(sub_in),
    .A(a_in), .B(b_in),
    .BUSY(busy32), .DONE(done32), .SUM(sum32), .COUT(cout32), .OVF(ovf32)
  );

  carry4_serial_addsub #(.WIDTH(4)) dut4 (
    .C(C), .CLR(CLR), .CE(CE), .START(start4), .SUB(sub_in),
    .A(a_in[3:0]), .B(b_in[3:0]),
    .BUSY(busy4), .DONE(done4), .SUM(sum4), .COUT(cout4), .OVF(ovf4)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge C);
    #1;
  endtask

  function automatic logic sel_done(input int w);
    case (w)
      8:       return done8;
      32:      return done32;
      default: return done4;
    endcase
  endfunction

  function automatic logic sel_busy(input int w);
    case (w)
      8:       return busy8;
      32:      return busy32;
      default: return busy4;
    endcase
  endfunction

  function automatic logic [31:0] sel_sum(input int w);
    case (w)
      8:       return {24'b0, sum8};
      32:      return sum32;
      default: return {28'b0, sum4};
    endcase
  endfunction

  function automatic logic sel_cout(input int w);
    case (w)
      8:       return cout8;
      32:      return cout32;
      default: return cout4;
    endcase
  endfunction

  function automatic logic sel_ovf(input int w);
    case (w)
      8:       return ovf8;
      32:      return ovf32;
      default: return ovf4;
    endcase
  endfunction

  // Presents operands with START for one edge; returns in cycle t+1.
  task automatic start_op(input int w, input logic [31:0] a, input logic [31:0] b, input logic sub);
    a_in   = a;
    b_in   = b;
    sub_in = sub;
    case (w)
      8:       start8  = 1'b1;
      32:      start32 = 1'b1;
      default: start4  = 1'b1;
    endcase
    tick();
    start8  = 1'b0;
    start32 = 1'b0;
    start4  = 1'b0;
  endtask

  // cyc counts cycles since the START edge; bounded so a missing DONE still ends the run.
  task automatic wait_done(input int w, input int first, output int cyc);
    cyc = first;
    while (!sel_done(w) && cyc < 60) begin
      tick();
      cyc++;
    end
  endtask

  task automatic op(input int w, input string tag, input logic [31:0] a, input logic [31:0] b,
                    input logic sub, input logic [31:0] exp_sum, input logic exp_cout,
                    input logic exp_ovf, input int exp_lat);
    int cyc;
    start_op(w, a, b, sub);
    chk({tag, "_busy_run"}, 32'(sel_busy(w)), 32'd1);
    chk({tag, "_done_run"}, 32'(sel_done(w)), 32'd0);
    wait_done(w, 1, cyc);
    chk({tag, "_lat"},  32'(cyc), 32'(exp_lat));
    chk({tag, "_sum"},  sel_sum(w), exp_sum);
    chk({tag, "_cout"}, 32'(sel_cout(w)), 32'(exp_cout));
    chk({tag, "_ovf"},  32'(sel_ovf(w)), 32'(exp_ovf));
    chk({tag, "_busy_done"}, 32'(sel_busy(w)), 32'd0);
  endtask

  initial begin
    int   cyc;
    logic any_done;

    CLR = 1'b1; CE = 1'b1; sub_in = 1'b0; a_in = '0; b_in = '0;
    start8 = 1'b0; start32 = 1'b0; start4 = 1'b0;
    tick();
    tick();
    chk("rst_busy", 32'(busy8), 32'd0);
    chk("rst_done", 32'(done8), 32'd0);
    chk("rst_sum",  32'(sum8),  32'd0);
    chk("rst_cout", 32'(cout8), 32'd0);
    chk("rst_ovf",  32'(ovf8),  32'd0);
    CLR = 1'b0;
    tick();

    op(8, "add5a3c", 32'h5A, 32'h3C, 1'b0, 32'h96, 1'b1 ^ 1'b1, 1'b1, 3);
    op(8, "sub1001", 32'h10, 32'h01, 1'b1, 32'h0F, 1'b1, 1'b0, 3);
    op(8, "sub0001", 32'h00, 32'h01, 1'b1, 32'hFF, 1'b0, 1'b0, 3);
    op(8, "addff01", 32'hFF, 32'h01, 1'b0, 32'h00, 1'b1, 1'b0, 3);
    // Started in the DONE cycle of the previous operation.
    op(8, "add7f01", 32'h7F, 32'h01, 1'b0, 32'h80, 1'b0, 1'b1, 3);

    // START while busy must be ignored.
    start_op(8, 32'h11, 32'h22, 1'b0);
    chk("ign_busy", 32'(busy8), 32'd1);
    a_in = 32'hAA; b_in = 32'hAA; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    wait_done(8, 2, cyc);
    chk("ign_lat", 32'(cyc), 32'd3);
    chk("ign_sum", 32'(sum8), 32'h33);
    tick();
    chk("ign_idle", 32'(busy8), 32'd0);

    // Three CE-low cycles mid-run stretch latency to t+6.
    start_op(8, 32'h21, 32'h43, 1'b0);
    CE = 1'b0;
    tick(); tick(); tick();
    CE = 1'b1;
    wait_done(8, 4, cyc);
    chk("ce_lat", 32'(cyc), 32'd6);
    chk("ce_sum", 32'(sum8), 32'h64);
    chk("ce_cout", 32'(cout8), 32'd0);
    CE = 1'b0;
    tick();
    chk("ce_done_hold", 32'(done8), 32'd1);
    chk("ce_sum_hold",  32'(sum8),  32'h64);
    CE = 1'b1;
    tick();
    chk("ce_done_drop", 32'(done8), 32'd0);

    // CLR after the first slice abandons the operation.
    start_op(8, 32'h5A, 32'h3C, 1'b0);
    tick();
    chk("clr_busy_pre", 32'(busy8), 32'd1);
    chk("clr_slice0",   32'(sum8),  32'h66);
    CLR = 1'b1;
    #1;
    chk("clr_busy", 32'(busy8), 32'd0);
    chk("clr_sum",  32'(sum8),  32'd0);
    chk("clr_done", 32'(done8), 32'd0);
    chk("clr_ovf",  32'(ovf8),  32'd0);
    tick();
    CLR = 1'b0;
    any_done = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      any_done = any_done | done8;
    end
    chk("clr_no_done", 32'(any_done), 32'd0);
    op(8, "postclr", 32'h10, 32'h01, 1'b1, 32'h0F, 1'b1, 1'b0, 3);

    op(32, "w32", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0, 1'b1, 1'b0, 9);
    op(4,  "w4",  32'h7, 32'h1, 1'b0, 32'h8, 1'b0, 1'b1, 2);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule
